// File: rtl/qsgmii_cfg_pkg.sv
// Shared constants, speed codes and restart FSM states for the QSGMII link supervisor.
// Pure declarations; no latency or flow-control behaviour.
package qsgmii_cfg_pkg;

    localparam logic [5:0]  CFG_VECTOR    = 6'h30;
    localparam logic [15:0] AN_ADV_VECTOR = 16'h0021;

    localparam logic [1:0] SPEED_1G  = 2'b10;
    localparam logic [1:0] SPEED_100 = 2'b01;
    localparam logic [1:0] SPEED_10  = 2'b00;
    localparam logic [1:0] SPEED_BAD = 2'b11;

    typedef enum logic [1:0] {
        IDLE,
        PULSE,
        HOLDOFF
    } restart_state_t;

endpackage

// File: rtl/qsgmii_speed_debounce.sv
// One channel's speed debounce: a new legal code commits after STABLE_CYCLES stable samples.
// Input-to-output latency is STABLE_CYCLES+1 edges; no backpressure.
module qsgmii_speed_debounce
    import qsgmii_cfg_pkg::*;
#(
    parameter int STABLE_CYCLES = 1024
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [1:0] speed,
    output logic [1:0] committed
);

    localparam int CW = $clog2(STABLE_CYCLES + 1);

    logic [1:0]    sample_q;
    logic [1:0]    prev_q;
    logic [1:0]    committed_q;
    logic [CW-1:0] cnt_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            sample_q    <= SPEED_1G;
            prev_q      <= SPEED_1G;
            committed_q <= SPEED_1G;
            cnt_q       <= '0;
        end else begin
            sample_q <= speed;
            prev_q   <= sample_q;
            if (sample_q == committed_q || sample_q == SPEED_BAD || sample_q != prev_q) begin
                cnt_q <= '0;
            end else if (cnt_q == CW'(STABLE_CYCLES - 2)) begin
                // The counter would reach STABLE_CYCLES-1 here: commit instead.
                committed_q <= sample_q;
                cnt_q       <= '0;
            end else begin
                cnt_q <= cnt_q + CW'(1);
            end
        end
    end

    assign committed = committed_q;

endmodule

// File: rtl/qsgmii_link_supervisor.sv
// Debounces per-channel speeds and restarts AN on cores whose channels stay down, round-robin.
// Speed out STABLE_CYCLES+1 edges after input; restart pulse LINK_TIMEOUT+2 edges after last drop; no backpressure.
module qsgmii_link_supervisor
    import qsgmii_cfg_pkg::*;
#(
    parameter int NUM_CORES      = 6,
    parameter int CH_PER_CORE    = 4,
    parameter int STABLE_CYCLES  = 1024,
    parameter int LINK_TIMEOUT   = 1250000,
    parameter int RESTART_PULSE  = 16,
    parameter int HOLDOFF_CYCLES = 125000,
    parameter int NCH            = NUM_CORES * CH_PER_CORE
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [2*NCH-1:0]     status_speed_in,
    input  logic [NCH-1:0]       status_link_in,
    output logic [NCH-1:0]       speed_is_10_100,
    output logic [NCH-1:0]       speed_is_100,
    output logic [NUM_CORES-1:0] an_restart_config,
    output logic [5:0]           configuration_vector,
    output logic [15:0]          an_adv_config_vector,
    output logic                 signal_detect,
    output logic [NCH-1:0]       link_up
);

    localparam int TW = $clog2(LINK_TIMEOUT + 1);
    localparam int PW = $clog2(RESTART_PULSE + 1);
    localparam int HW = $clog2(HOLDOFF_CYCLES + 1);
    localparam int CW = (PW > HW) ? PW : HW;
    localparam int GW = $clog2(NUM_CORES + 1);

    assign configuration_vector = CFG_VECTOR;
    assign an_adv_config_vector = AN_ADV_VECTOR;
    assign signal_detect        = 1'b1;

    for (genvar n = 0; n < NCH; n++) begin : g_ch
        logic [1:0] spd;
        qsgmii_speed_debounce #(.STABLE_CYCLES(STABLE_CYCLES)) u_debounce (
            .clk       (clk),
            .reset     (reset),
            .speed     (status_speed_in[2*n +: 2]),
            .committed (spd)
        );
        assign speed_is_10_100[n] = ~spd[1];
        assign speed_is_100[n]    = spd[0];
    end

    logic [NCH-1:0]       link_q;
    logic [NUM_CORES-1:0] core_up;
    logic [TW-1:0]        timer_q [NUM_CORES];
    logic [NUM_CORES-1:0] pending_q;
    restart_state_t       state_q;
    logic [GW-1:0]        last_grant_q;
    logic [CW-1:0]        cnt_q;
    logic                 grant_found;
    logic [GW-1:0]        grant_idx;
    logic                 grant_take;

    always_ff @(posedge clk) begin
        if (reset) link_q <= '0;
        else       link_q <= status_link_in;
    end

    assign link_up = link_q;

    always_comb begin
        for (int c = 0; c < NUM_CORES; c++) begin
            core_up[c] = |link_q[c*CH_PER_CORE +: CH_PER_CORE];
        end
    end

    // First pending core strictly after the last one served.
    always_comb begin
        int idx;
        idx         = 0;
        grant_found = 1'b0;
        grant_idx   = '0;
        for (int i = 1; i <= NUM_CORES; i++) begin
            idx = int'(last_grant_q) + i;
            if (idx >= NUM_CORES) idx = idx - NUM_CORES;
            if (!grant_found && pending_q[idx]) begin
                grant_found = 1'b1;
                grant_idx   = GW'(idx);
            end
        end
    end

    assign grant_take = (state_q == IDLE) && grant_found;

    always_ff @(posedge clk) begin
        if (reset) begin
            pending_q <= '0;
            for (int c = 0; c < NUM_CORES; c++) timer_q[c] <= '0;
        end else begin
            for (int c = 0; c < NUM_CORES; c++) begin
                if (core_up[c]) begin
                    timer_q[c]   <= '0;
                    pending_q[c] <= 1'b0;
                end else if (state_q == HOLDOFF && last_grant_q == GW'(c)) begin
                    timer_q[c] <= '0;
                end else begin
                    if (grant_take && grant_idx == GW'(c)) pending_q[c] <= 1'b0;
                    if (timer_q[c] == TW'(LINK_TIMEOUT - 1)) begin
                        timer_q[c]   <= '0;
                        pending_q[c] <= 1'b1;
                    end else begin
                        timer_q[c] <= timer_q[c] + TW'(1);
                    end
                end
            end
        end
    end

    // last_grant_q doubles as the core being served while in PULSE/HOLDOFF.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q           <= IDLE;
            last_grant_q      <= GW'(NUM_CORES - 1);
            cnt_q             <= '0;
            an_restart_config <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (grant_found) begin
                        last_grant_q      <= grant_idx;
                        cnt_q             <= CW'(RESTART_PULSE - 1);
                        an_restart_config <= NUM_CORES'(1) << grant_idx;
                        state_q           <= PULSE;
                    end
                end
                PULSE: begin
                    if (cnt_q == '0) begin
                        an_restart_config <= '0;
                        cnt_q             <= CW'(HOLDOFF_CYCLES - 1);
                        state_q           <= HOLDOFF;
                    end else begin
                        cnt_q <= cnt_q - CW'(1);
                    end
                end
                HOLDOFF: begin
                    if (cnt_q == '0) state_q <= IDLE;
                    else             cnt_q   <= cnt_q - CW'(1);
                end
                default: begin
                    an_restart_config <= '0;
                    state_q           <= IDLE;
                end
            endcase
        end
    end

endmodule
